// File: rtl/mmio_bridge.sv
// mmio_bridge
//   Registers a single CPU load/store access, decodes the peripheral window
//   (addr[15:12] == PERIPH_BASE) and drives the peripheral bus until it
//   signals ready or the access times out. Completion is a one-cycle
//   acknowledge with read data and an error flag; errors are counted.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   cpu_req    single-cycle access strobe; cpu_addr/cpu_we/cpu_wdata valid with it
//   cpu_rdata  read data, valid while cpu_ack=1 (holds otherwise)
//   cpu_ack    one-cycle completion pulse
//   cpu_err    error flag (window miss or timeout), valid while cpu_ack=1
//   busy       1 whenever the bridge is not idle
//   pb_addr    registered bus address
//   pb_sel     bus select, high for the whole bus access
//   pb_we      bus write strobe
//   pb_re      bus read strobe
//   pb_wdata   registered bus write data
//   pb_rdata   bus read data
//   pb_rdy     bus ready (combinational from the bus)
//   err_count  saturating count of error completions
module mmio_bridge #(
    parameter logic [3:0]  PERIPH_BASE    = 4'h8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        busy,
    output logic [15:0] pb_addr,
    output logic        pb_sel,
    output logic        pb_we,
    output logic        pb_re,
    output logic [15:0] pb_wdata,
    input  logic [15:0] pb_rdata,
    input  logic        pb_rdy,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        wr_q;
    logic [15:0] cpu_rdata_q;
    logic        cpu_ack_q;
    logic        cpu_err_q;
    logic [15:0] pb_addr_q;
    logic        pb_sel_q;
    logic        pb_we_q;
    logic        pb_re_q;
    logic [15:0] pb_wdata_q;
    logic [7:0]  err_count_q;

    logic        win_hit;
    logic [7:0]  err_count_d;

    assign win_hit = (cpu_addr[15:12] == PERIPH_BASE);

    always_comb begin
        err_count_d = err_count_q;
        if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Outputs are registered: each one is set on the edge that enters the
    // state in which it must be visible, and cleared on the edge that leaves it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            pb_addr_q   <= '0;
            pb_sel_q    <= 1'b0;
            pb_we_q     <= 1'b0;
            pb_re_q     <= 1'b0;
            pb_wdata_q  <= '0;
            err_count_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            cpu_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        pb_addr_q  <= cpu_addr;
                        wr_q       <= cpu_we;
                        pb_wdata_q <= cpu_wdata;
                        cnt_q      <= '0;
                        if (win_hit) begin
                            state_q  <= ACCESS;
                            pb_sel_q <= 1'b1;
                            pb_we_q  <= cpu_we;
                            pb_re_q  <= !cpu_we;
                        end else begin
                            state_q     <= RESP;
                            cpu_ack_q   <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (pb_rdy) begin
                        state_q     <= RESP;
                        pb_sel_q    <= 1'b0;
                        pb_we_q     <= 1'b0;
                        pb_re_q     <= 1'b0;
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= 1'b0;
                        cpu_rdata_q <= wr_q ? 16'h0000 : pb_rdata;
                    end else if (cnt_q == TO_LAST) begin
                        state_q     <= RESP;
                        pb_sel_q    <= 1'b0;
                        pb_we_q     <= 1'b0;
                        pb_re_q     <= 1'b0;
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        cpu_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    // cpu_err_q is only ever high during RESP
                    if (cpu_err_q) begin
                        err_count_q <= err_count_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign busy      = (state_q != IDLE);
    assign pb_addr   = pb_addr_q;
    assign pb_sel    = pb_sel_q;
    assign pb_we     = pb_we_q;
    assign pb_re     = pb_re_q;
    assign pb_wdata  = pb_wdata_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        busy;
    logic [15:0] pb_addr;
    logic        pb_sel;
    logic        pb_we;
    logic        pb_re;
    logic [15:0] pb_wdata;
    logic [15:0] pb_rdata;
    logic        pb_rdy;
    logic [7:0]  err_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state kept by the bench
    int unsigned m_err_cnt   = 0;
    logic [15:0] m_last_rdat = '0;

    mmio_bridge #(
        .PERIPH_BASE   (4'h8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .cpu_err  (cpu_err),
        .busy     (busy),
        .pb_addr  (pb_addr),
        .pb_sel   (pb_sel),
        .pb_we    (pb_we),
        .pb_re    (pb_re),
        .pb_wdata (pb_wdata),
        .pb_rdata (pb_rdata),
        .pb_rdy   (pb_rdy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access. The bench plays the peripheral: pb_rdy stays low for
    // 'w' ACCESS cycles, then goes high. Expected timing and results are derived
    // from the access rules: miss -> ack after 1 cycle with error; w >= T ->
    // timeout ack after T+1 cycles with error; otherwise ack after w+2 cycles.
    task automatic do_txn(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                          input int unsigned w, input bit extra_req);
        bit          hit;
        int unsigned acc;
        int unsigned lat;
        logic        eerr;
        logic [15:0] erd;
        hit = (addr[15:12] == 4'h8);
        erd = '0;
        if (!hit) begin
            acc = 0; lat = 1; eerr = 1'b1;
        end else if (w >= T) begin
            acc = T; lat = T + 1; eerr = 1'b1;
        end else begin
            acc = w + 1; lat = w + 2; eerr = 1'b0;
        end
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        cpu_we    = we;
        cpu_wdata = wdata;
        pb_rdy    = 1'b0;
        tick();
        cpu_req = 1'b0;
        for (int unsigned c = 1; c <= lat + 1; c++) begin
            pb_rdy   = (c > w);
            pb_rdata = 16'($urandom);
            if (c == acc && !eerr) erd = we ? 16'h0000 : pb_rdata;
            if (extra_req && c == 1) begin
                cpu_req  = 1'b1;
                cpu_addr = 16'h8000;
            end
            if (extra_req && c == 2) cpu_req = 1'b0;
            check("pb_sel", pb_sel, (c <= acc));
            if (c <= acc) begin
                check("pb_we", pb_we, we);
                check("pb_re", pb_re, !we);
                check("pb_addr", pb_addr, addr);
                check("pb_wdata", pb_wdata, wdata);
            end else begin
                check("pb_we_idle", pb_we, 1'b0);
                check("pb_re_idle", pb_re, 1'b0);
            end
            check("cpu_ack", cpu_ack, (c == lat));
            check("busy", busy, (c <= lat));
            if (c == lat) begin
                check("cpu_err", cpu_err, eerr);
                check("cpu_rdata", cpu_rdata, erd);
                m_last_rdat = erd;
                if (eerr && m_err_cnt < 255) m_err_cnt++;
            end else begin
                check("cpu_err_idle", cpu_err, 1'b0);
                check("cpu_rdata_hold", cpu_rdata, m_last_rdat);
            end
            if (c == lat + 1) check("err_count", err_count, m_err_cnt);
            else tick();
        end
        pb_rdy = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 16'h0);
        check({tag, "_ack"}, cpu_ack, 1'b0);
        check({tag, "_err"}, cpu_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_addr"}, pb_addr, 16'h0);
        check({tag, "_sel"}, pb_sel, 1'b0);
        check({tag, "_we"}, pb_we, 1'b0);
        check({tag, "_re"}, pb_re, 1'b0);
        check({tag, "_wdata"}, pb_wdata, 16'h0);
        check({tag, "_errcnt"}, err_count, 8'h0);
    endtask

    initial begin
        logic [15:0] ra;
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_we    = 1'b0;
        cpu_wdata = '0;
        pb_rdata  = '0;
        pb_rdy    = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Directed: zero-wait read, 3-wait write, timeout read, window miss
        do_txn(16'h8104, 1'b0, 16'h0000, 0, 1'b0);
        do_txn(16'h8200, 1'b1, 16'h00A5, 3, 1'b0);
        do_txn(16'h8300, 1'b0, 16'h0000, 1000, 1'b0);
        do_txn(16'h1000, 1'b0, 16'h0000, 0, 1'b1);
        // rdy in the last counted cycle still succeeds; one cycle later times out
        do_txn(16'h8010, 1'b0, 16'h0000, T - 1, 1'b1);
        do_txn(16'h8020, 1'b0, 16'h0000, T, 1'b0);
        // Window edges
        do_txn(16'h8FFF, 1'b0, 16'h0000, 1, 1'b0);
        do_txn(16'h7FFF, 1'b1, 16'h5555, 0, 1'b0);
        do_txn(16'h9000, 1'b0, 16'h0000, 0, 1'b0);

        // Reset in the middle of an access (second wait cycle)
        cpu_req  = 1'b1;
        cpu_addr = 16'h8300;
        cpu_we   = 1'b0;
        pb_rdy   = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_err_cnt   = 0;
        m_last_rdat = '0;
        check_all_zero("midrst");
        for (int i = 0; i < 20; i++) begin
            check("midrst_no_ack", cpu_ack, 1'b0);
            tick();
        end
        do_txn(16'h8444, 1'b0, 16'h0000, 2, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ra[15:12] = 4'h8;
            do_txn(ra, 1'($urandom), 16'($urandom), $urandom_range(0, T + 3),
                   1'($urandom_range(0, 1)));
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            do_txn(16'h8300, 1'b0, 16'h0000, 1000, 1'b0);
        end
        do_txn(16'h2000, 1'b1, 16'h1111, 0, 1'b0);
        check("err_sat", err_count, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly upstream of the peripheral bus, between the CPU load/store port and the bus sel/we/re/rdy interface.
- Registers each CPU access and decodes the peripheral window (addr[15:12] == PERIPH_BASE, i.e. 0x8000-0x8FFF).
- Holds the bus request until the bus signals rdy, then returns a one-cycle acknowledge with read data to the CPU.
- Bounds every access with a timeout and reports window misses and timeouts as a bus error.

Parameters:
PERIPH_BASE, 4'h8, value of addr[15:12] that selects the peripheral window
TIMEOUT_CYCLES, 16, maximum ACCESS-state cycles before a timeout error (range 2..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
cpu_req  input  1  single-cycle access strobe from CPU
cpu_addr  input  16  byte address, valid with cpu_req
cpu_we  input  1  1 = write, 0 = read, valid with cpu_req
cpu_wdata  input  16  write data, valid with cpu_req
cpu_rdata  output  16  read data, valid while cpu_ack=1
cpu_ack  output  1  one-cycle completion pulse
cpu_err  output  1  error flag, valid while cpu_ack=1
busy  output  1  1 in any state other than IDLE
pb_addr  output  16  registered address to the peripheral bus
pb_sel  output  1  peripheral bus select
pb_we  output  1  peripheral bus write strobe
pb_re  output  1  peripheral bus read strobe
pb_wdata  output  16  registered write data
pb_rdata  input  16  read data from the peripheral bus
pb_rdy  input  1  peripheral bus ready (combinational from the bus)
err_count  output  8  saturating count of error completions

Behaviour:
- Reset (rst=0 at a clock edge):
  - Next state is IDLE; any in-flight access is dropped with no ack.
  - All outputs go to 0 (cpu_rdata, pb_addr, pb_wdata, err_count = 0).
- FSM states: IDLE, ACCESS, RESP.
- IDLE, cpu_req=1 at edge N:
  - Latch cpu_addr, cpu_we and cpu_wdata into pb_addr, an internal write flag and pb_wdata.
  - Clear the timeout counter.
  - If cpu_addr[15:12]==PERIPH_BASE: go to ACCESS. Otherwise: go to RESP with err=1 and cpu_rdata=0; the bus is never touched.
- ACCESS:
  - pb_sel=1, pb_we=write flag, pb_re=!write flag; all three are held constant for the whole state.
  - Bus contract: peripherals commit side effects only in the cycle pb_rdy=1.
  - pb_rdy=1: capture pb_rdata into cpu_rdata on reads (0 on writes), err=0, go to RESP.
  - pb_rdy=0: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with pb_rdy still 0, go to RESP with err=1 and cpu_rdata=0.
  - pb_rdy=1 in the final counted cycle counts as success; rdy takes priority over timeout.
- RESP:
  - cpu_ack=1 for exactly one cycle, with cpu_err=err.
  - pb_sel, pb_we and pb_re are all 0.
  - If err=1, err_count increments, saturating at 8'hFF.
  - Always return to IDLE.
- Latency: with pb_rdy=1 on the first ACCESS cycle, a request at edge N gives ACCESS during cycle N+1 and cpu_ack high during cycle N+2 (2-cycle access). Each wait cycle adds one.
- Timeout: an access with pb_rdy stuck at 0 acks TIMEOUT_CYCLES+1 cycles after the request.
- A window miss acks one cycle after the request.
- cpu_req sampled in ACCESS or RESP is ignored: no queuing, no ack. The CPU must not issue a new request before the ack.
- A request in the cycle immediately after RESP (bridge back in IDLE) is accepted normally, giving back-to-back throughput of one access per 3 cycles at zero wait states.
- Outside RESP, cpu_rdata holds its last value and cpu_err=0.

Test Plan:
- Read 0x8104, pb_rdy=1 immediately, pb_rdata=16'h1234 -> pb_sel/pb_re high for 1 cycle with pb_addr=0x8104; cpu_ack 2 cycles after cpu_req with cpu_rdata=0x1234, cpu_err=0.
- Write 0x8200 data 16'h00A5, pb_rdy low for 3 cycles then high -> pb_we/pb_sel/pb_wdata stable for 4 cycles; single cpu_ack 5 cycles after cpu_req, cpu_err=0, err_count=0.
- Read 0x8300 with pb_rdy stuck at 0, TIMEOUT_CYCLES=16 -> pb_sel deasserts after 16 cycles; cpu_ack with cpu_err=1 and cpu_rdata=0; err_count=1.
- Read 0x1000 (outside the window) -> pb_sel never asserted; cpu_ack next cycle with cpu_err=1; a second cpu_req pulse during busy produces no extra ack.
- Assert rst=0 mid-ACCESS at wait cycle 2 -> all outputs 0 after that edge, no ack; a request after rst returns to 1 completes normally.
- Force 256 timeout errors -> err_count saturates at 8'hFF and stays there on further errors.
